// File: rtl/halflife_pkg.sv
// Shared state encoding and default parameter values for the half-life decay timer.
package halflife_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_t;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_PW    = 16;
  localparam int unsigned DEF_HW    = 4;
  localparam int unsigned DEF_ROUND = 0;

endpackage

// File: rtl/halflife_prescaler.sv
// Free-running 0..period-1 counter; terminal pulses on the enabled clock that wraps it.
module halflife_prescaler
  import halflife_pkg::*;
#(
  parameter int unsigned PW = DEF_PW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          clear,
  input  logic [PW-1:0] period,
  output logic          terminal
);

  logic [PW-1:0] cnt;

  // period is never zero here; the owner coerces 0 to 1 when capturing it
  assign terminal = enable && (cnt == period - PW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= terminal ? '0 : cnt + PW'(1);
    end
  end

endmodule

// File: rtl/halflife_decay_timer.sv
// Quantity that halves once per programmable period while running; IDLE allows manual trim.
module halflife_decay_timer
  import halflife_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned PW    = DEF_PW,
  parameter int unsigned HW    = DEF_HW,
  parameter int unsigned ROUND = DEF_ROUND
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [PW-1:0]    period_val,
  input  logic             start,
  input  logic             stop,
  input  logic             up,
  input  logic             down,
  output logic [WIDTH-1:0] count_out,
  output logic [HW-1:0]    halvings,
  output logic             running,
  output logic             tick,
  output logic             done
);

  state_t           state, state_nx;
  logic [PW-1:0]    period_q;
  logic [WIDTH-1:0] count_nx;
  logic [HW-1:0]    halv_nx;
  logic             tick_nx, done_nx;
  logic             pre_en, pre_term;
  logic [WIDTH:0]   plus_one;
  logic [WIDTH-1:0] half_val;

  // stop and load both freeze the prescaler on the edge they are sampled
  assign pre_en = (state == ST_RUN) && !load && !stop;

  halflife_prescaler #(
    .PW(PW)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .enable  (pre_en),
    .clear   (load),
    .period  (period_q),
    .terminal(pre_term)
  );

  assign plus_one = {1'b0, count_out} + (WIDTH+1)'(1);

  always_comb begin
    if (ROUND != 0) begin
      half_val = (count_out == WIDTH'(1)) ? '0 : plus_one[WIDTH:1];
    end else begin
      half_val = count_out >> 1;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count_out;
    halv_nx  = halvings;
    tick_nx  = 1'b0;
    done_nx  = 1'b0;
    if (load) begin
      state_nx = ST_IDLE;
      count_nx = load_val;
      halv_nx  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!stop) begin
            if (start) begin
              if (count_out != '0) begin
                state_nx = ST_RUN;
              end else begin
                state_nx = ST_DONE;
                done_nx  = 1'b1;
              end
            end else if (up && !down) begin
              if (count_out != '1) count_nx = count_out + WIDTH'(1);
            end else if (down && !up) begin
              if (count_out != '0) count_nx = count_out - WIDTH'(1);
            end
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_nx = ST_PAUSE;
          end else if (pre_term) begin
            count_nx = half_val;
            tick_nx  = 1'b1;
            if (halvings != '1) halv_nx = halvings + HW'(1);
            if (half_val == '0) begin
              state_nx = ST_DONE;
              done_nx  = 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (!stop && start) state_nx = ST_RUN;
        end
        default: state_nx = ST_DONE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      period_q  <= PW'(1);
      count_out <= '0;
      halvings  <= '0;
      running   <= 1'b0;
      tick      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      count_out <= count_nx;
      halvings  <= halv_nx;
      running   <= (state_nx == ST_RUN);
      tick      <= tick_nx;
      done      <= done_nx;
      if (load) period_q <= (period_val == '0) ? PW'(1) : period_val;
    end
  end

endmodule

// File: tb/tb_halflife_decay_timer.sv
// Scoreboard bench: floor and round-half-up instances share stimulus and a behavioural model.
module tb_halflife_decay_timer;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  typedef struct packed {
    logic [7:0] cnt;
    logic [3:0] h;
    logic       run;
    logic       tick;
    logic       done;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [7:0]  load_val = '0;
  logic [15:0] period_val = '0;
  logic        start = 1'b0, stop = 1'b0, up = 1'b0, down = 1'b0;
  logic [7:0]  c0, c1;
  logic [3:0]  h0, h1;
  logic        r0, r1, t0, t1, d0, d1;

  int checks = 0;
  int failures = 0;

  exp_t q0[$];
  exp_t q1[$];

  int m_cnt[2], m_per[2], m_h[2], m_el[2], m_mode[2];
  bit m_tick[2], m_done[2];

  always #5 clk = ~clk;

  halflife_decay_timer #(.WIDTH(8), .PW(16), .HW(4), .ROUND(0)) u_floor (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .period_val(period_val),
    .start(start), .stop(stop), .up(up), .down(down),
    .count_out(c0), .halvings(h0), .running(r0), .tick(t0), .done(d0)
  );

  halflife_decay_timer #(.WIDTH(8), .PW(16), .HW(4), .ROUND(1)) u_round (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .period_val(period_val),
    .start(start), .stop(stop), .up(up), .down(down),
    .count_out(c1), .halvings(h1), .running(r1), .tick(t1), .done(d1)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_per[i] = 1; m_h[i] = 0; m_el[i] = 0;
      m_mode[i] = M_IDLE; m_tick[i] = 0; m_done[i] = 0;
    end
  endtask

  // One clock of behaviour: elapsed run clocks reaching the period triggers a halving.
  task automatic model_step(input int i);
    int nv;
    m_tick[i] = 0;
    m_done[i] = 0;
    if (load) begin
      m_cnt[i] = load_val; m_per[i] = (period_val == 0) ? 1 : period_val;
      m_h[i] = 0; m_el[i] = 0; m_mode[i] = M_IDLE;
    end else if (m_mode[i] == M_IDLE) begin
      if (stop) begin
      end else if (start) begin
        if (m_cnt[i] != 0) m_mode[i] = M_RUN;
        else begin m_mode[i] = M_DONE; m_done[i] = 1; end
      end else if (up && !down) begin
        if (m_cnt[i] < 255) m_cnt[i]++;
      end else if (down && !up) begin
        if (m_cnt[i] > 0) m_cnt[i]--;
      end
    end else if (m_mode[i] == M_RUN) begin
      if (stop) m_mode[i] = M_PAUSE;
      else begin
        m_el[i]++;
        if (m_el[i] == m_per[i]) begin
          m_el[i] = 0;
          if (i == 1) nv = (m_cnt[i] == 1) ? 0 : (m_cnt[i] + 1) / 2;
          else nv = m_cnt[i] / 2;
          m_cnt[i] = nv;
          m_tick[i] = 1;
          if (m_h[i] < 15) m_h[i]++;
          if (nv == 0) begin m_mode[i] = M_DONE; m_done[i] = 1; end
        end
      end
    end else if (m_mode[i] == M_PAUSE) begin
      if (!stop && start) m_mode[i] = M_RUN;
    end
  endtask

  function automatic exp_t snap(input int i);
    exp_t e;
    e.cnt  = 8'(m_cnt[i]);
    e.h    = 4'(m_h[i]);
    e.run  = (m_mode[i] == M_RUN);
    e.tick = m_tick[i];
    e.done = m_done[i];
    return e;
  endfunction

  // Called at a negedge: drive, predict the next edge, queue expectations, advance one clock.
  task automatic cyc(input logic l, input int lv, input int pv,
                     input logic s, input logic sp, input logic u, input logic d);
    load = l; load_val = 8'(lv); period_val = 16'(pv);
    start = s; stop = sp; up = u; down = d;
    for (int i = 0; i < 2; i++) model_step(i);
    q0.push_back(snap(0));
    q1.push_back(snap(1));
    @(negedge clk);
    load = 1'b0; start = 1'b0; stop = 1'b0; up = 1'b0; down = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_count_f"}, c0, 0); chk({tag, "_count_r"}, c1, 0);
    chk({tag, "_halv_f"}, h0, 0);  chk({tag, "_halv_r"}, h1, 0);
    chk({tag, "_run_f"}, r0, 0);   chk({tag, "_run_r"}, r1, 0);
    chk({tag, "_tick_f"}, t0, 0);  chk({tag, "_done_f"}, d0, 0);
  endtask

  // Monitor: every edge the DUTs present a fresh registered output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0 && q1.size() > 0) begin
        e = q0.pop_front();
        chk("floor_count", c0, e.cnt); chk("floor_halvings", h0, e.h);
        chk("floor_running", r0, e.run); chk("floor_tick", t0, e.tick);
        chk("floor_done", d0, e.done);
        e = q1.pop_front();
        chk("round_count", c1, e.cnt); chk("round_halvings", h1, e.h);
        chk("round_running", r1, e.run); chk("round_tick", t1, e.tick);
        chk("round_done", d1, e.done);
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_zero("reset_init");

    // 200 with period 3 until done
    cyc(1, 200, 3, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    idle(30);
    chk("p3_floor_final_count", c0, 0); chk("p3_floor_halvings", h0, 8);
    chk("p3_round_halvings", h1, 9);

    // 25 with period 1
    cyc(1, 25, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    idle(8);
    chk("p1_round_halvings", h1, 6); chk("p1_floor_halvings", h0, 5);

    // pause and resume keeps prescaler phase
    cyc(1, 80, 4, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    idle(6);
    cyc(0, 0, 0, 0, 1, 0, 0);
    idle(5);
    chk("pause_count", c0, 40); chk("pause_running", r0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    idle(1);
    chk("resume_plus1_count", c0, 40);
    idle(1);
    chk("resume_plus2_count", c0, 20);
    idle(12);

    // idle trim saturation and zero start
    cyc(1, 255, 1, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0, 1, 0);
    chk("up_sat", c0, 255);
    cyc(1, 0, 1, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0, 0, 1);
    chk("down_sat", c0, 0);
    cyc(1, 10, 1, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0, 1, 1);
    chk("up_down_both", c0, 10);
    cyc(1, 0, 0, 0, 0, 0, 0); cyc(0, 0, 0, 1, 0, 0, 0);
    chk("zero_start_done", d0, 1);
    cyc(0, 0, 0, 1, 1, 1, 0);
    chk("done_one_cycle", d0, 0); chk("done_holds_count", c0, 0);

    // load with stop mid-run
    cyc(1, 200, 2, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    idle(6);
    chk("pre_load_halvings", h0, 3);
    cyc(1, 9, 2, 0, 1, 0, 0);
    chk("load_stop_count", c0, 9); chk("load_stop_halv", h0, 0);
    chk("load_stop_run", r0, 0);

    // asynchronous reset mid-run
    cyc(1, 200, 2, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    idle(3);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check_zero("reset_midrun");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("post_reset_idle_start", r0, 0);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic l, s, sp, u, d;
      int lv, pv, sel;
      l  = ($urandom_range(0, 99) < 3);
      s  = ($urandom_range(0, 99) < 20);
      sp = ($urandom_range(0, 99) < 5);
      u  = ($urandom_range(0, 99) < 10);
      d  = ($urandom_range(0, 99) < 10);
      sel = $urandom_range(0, 9);
      lv = (sel == 0) ? 0 : (sel == 1) ? 1 : (sel == 2) ? 255 : $urandom_range(0, 255);
      pv = $urandom_range(0, 4);
      cyc(l, lv, pv, s, sp, u, d);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drain", q0.size() + q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
